// File: rtl/seq_booth_multiplier_if.sv
// Handshake and operand bundle for the sequential
// radix-4 Booth multiplier.
interface seq_booth_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 ready;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, is_signed, x, y,
    input  ready, done, product
  );

  modport slave (
    input  start, is_signed, x, y,
    output ready, done, product
  );
endinterface

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-4 Booth multiplier, one Booth
// digit per cycle over WIDTH+2 extended operands.
module seq_booth_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_booth_multiplier_if.slave bus
);

  localparam int EW   = WIDTH + 2;
  localparam int AW   = EW + 2;
  localparam int ITER = (WIDTH / 2) + 1;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [EW-1:0]       mcand;
  logic [AW-1:0]       acc;
  logic [EW-1:0]       mplr;
  logic                qm1;
  logic [CW-1:0]       cnt;
  logic [2*WIDTH-1:0]  prod;

  logic [AW-1:0]       mc1;
  logic [AW-1:0]       mc2;
  logic [AW-1:0]       pp;
  logic [AW-1:0]       sum;
  logic [AW-1:0]       acc_nx;
  logic [EW-1:0]       mplr_nx;
  logic                last;
  logic                sx;
  logic                sy;

  assign sx   = bus.is_signed & bus.x[WIDTH-1];
  assign sy   = bus.is_signed & bus.y[WIDTH-1];
  assign last = (cnt == CW'(1));
  assign mc1  = {{2{mcand[EW-1]}}, mcand};
  assign mc2  = {mc1[AW-2:0], 1'b0};

  // Booth digit select: partial product from the
  // low multiplier pair plus the shifted-out bit.
  always_comb begin
    pp = '0;
    unique case ({mplr[1:0], qm1})
      3'b001,
      3'b010:  pp = mc1;
      3'b011:  pp = mc2;
      3'b100:  pp = -mc2;
      3'b101,
      3'b110:  pp = -mc1;
      default: pp = '0;
    endcase
  end

  // Accumulate then arithmetic shift the
  // accumulator/multiplier pair right by two.
  always_comb begin
    sum     = acc + pp;
    acc_nx  = {{2{sum[AW-1]}}, sum[AW-1:2]};
    mplr_nx = {sum[1:0], mplr[EW-1:2]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_nx = CALC;
      end
      CALC: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, Booth iteration and result
  // register; the result moves only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      prod  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= {{2{sx}}, bus.x};
            mplr  <= {{2{sy}}, bus.y};
            acc   <= '0;
            qm1   <= 1'b0;
            cnt   <= CW'(ITER);
          end
        end
        CALC: begin
          acc  <= acc_nx;
          mplr <= mplr_nx;
          qm1  <= mplr[1];
          cnt  <= cnt - CW'(1);
          if (last) begin
            prod <= {acc_nx[WIDTH-3:0], mplr_nx};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.product = prod;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard bench for the Booth multiplier at
// WIDTH=16 (directed + random) and WIDTH=8 (random).
module tb_seq_booth_multiplier;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_booth_multiplier_if #(.WIDTH(16)) m16 ();
  seq_booth_multiplier_if #(.WIDTH(8))  m8 ();

  seq_booth_multiplier #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (m16.slave)
  );

  seq_booth_multiplier #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (m8.slave)
  );

  int          n_chk = 0;
  int          n_err = 0;
  longint      cyc   = 0;
  int          b2b   = 0;

  logic [63:0] sb16[$];
  logic [63:0] sb8[$];
  logic [63:0] hold16 = '0;
  logic [63:0] hold8  = '0;
  longint      acc16  = 0;
  longint      acc8   = 0;
  longint      prev16 = -1;
  longint      prev8  = -1;
  int          push16 = 0;
  int          push8  = 0;
  int          dn16   = 0;
  int          dn8    = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s,
    input int          w
  );
    longint      av;
    longint      bv;
    longint      p;
    logic [63:0] mask;
    av = longint'(a);
    bv = longint'(b);
    if (s && a[w-1]) av = av - (64'sd1 <<< w);
    if (s && b[w-1]) bv = bv - (64'sd1 <<< w);
    p    = av * bv;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sb16.delete();
      sb8.delete();
      hold16 = '0;
      hold8  = '0;
    end
  end

  // WIDTH=16 monitor: ITER=9, done seen at edge
  // N+10, back-to-back spacing 11.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (m16.done) begin
        dn16++;
        if (sb16.size() == 0) begin
          check("done16_spurious", 64'd1, 64'd0);
        end else begin
          e = sb16.pop_front();
          check("prod16", 64'(m16.product), e);
          check("lat16", 64'(cyc + 1 - acc16), 64'd10);
          hold16 = e;
          if (b2b != 0 && prev16 >= 0)
            check("space16", 64'(cyc - prev16), 64'd11);
          prev16 = cyc;
        end
      end else begin
        check("hold16", 64'(m16.product), hold16);
      end
      if (m16.ready && m16.start) begin
        sb16.push_back(ref_mul(32'(m16.x),
          32'(m16.y), m16.is_signed, 16));
        acc16 = cyc + 1;
        push16++;
      end
    end
  end

  // WIDTH=8 monitor: ITER=5, latency 6, spacing 7.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (m8.done) begin
        dn8++;
        if (sb8.size() == 0) begin
          check("done8_spurious", 64'd1, 64'd0);
        end else begin
          e = sb8.pop_front();
          check("prod8", 64'(m8.product), e);
          check("lat8", 64'(cyc + 1 - acc8), 64'd6);
          hold8 = e;
          if (b2b != 0 && prev8 >= 0)
            check("space8", 64'(cyc - prev8), 64'd7);
          prev8 = cyc;
        end
      end else begin
        check("hold8", 64'(m8.product), hold8);
      end
      if (m8.ready && m8.start) begin
        sb8.push_back(ref_mul(32'(m8.x),
          32'(m8.y), m8.is_signed, 8));
        acc8 = cyc + 1;
        push8++;
      end
    end
  end

  task automatic wait_idle(input int w);
    int  n;
    logic busy;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (w == 16) busy = (sb16.size() != 0) || !m16.ready;
      else         busy = (sb8.size() != 0) || !m8.ready;
    end while (busy && n < 100);
    if (busy) check("timeout", 64'd1, 64'd0);
  endtask

  task automatic do_op16(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        s,
    input logic [31:0] exp,
    input string       tag
  );
    @(posedge clk); #1;
    m16.x = a;
    m16.y = b;
    m16.is_signed = s;
    m16.start = 1'b1;
    @(posedge clk); #1;
    m16.start = 1'b0;
    wait_idle(16);
    check(tag, 64'(m16.product), 64'(exp));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int tgt;
    int n;
    rst = 1'b1;
    m16.start = 1'b0;
    m16.is_signed = 1'b0;
    m16.x = '0;
    m16.y = '0;
    m8.start = 1'b0;
    m8.is_signed = 1'b0;
    m8.x = '0;
    m8.y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(m16.ready), 64'd1);
    check("rst_done", 64'(m16.done), 64'd0);
    check("rst_prod", 64'(m16.product), 64'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    m16.x = 16'h7FFF;
    m16.y = 16'h007F;
    m16.is_signed = 1'b0;
    m16.start = 1'b1;
    @(posedge clk); #1;
    m16.start = 1'b0;
    @(negedge clk);
    check("first_accept", 64'(m16.ready), 64'd0);
    wait_idle(16);
    check("u7fff_7f", 64'(m16.product), 64'h003F7F81);

    do_op16(16'h8000, 16'h00F0, 1'b1, 32'hFF880000, "s8000_f0");
    do_op16(16'h8000, 16'h00F0, 1'b0, 32'h00780000, "u8000_f0");
    do_op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_ones");
    do_op16(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "s_ones");
    do_op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_minneg");
    do_op16(16'h0000, 16'h1234, 1'b1, 32'h00000000, "zero");

    d0 = dn16;
    @(posedge clk); #1;
    m16.x = 16'h1234;
    m16.y = 16'h0056;
    m16.is_signed = 1'b0;
    m16.start = 1'b1;
    @(posedge clk); #1;
    m16.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m16.x = 16'hFFFF;
    m16.y = 16'hFFFF;
    m16.is_signed = 1'b1;
    m16.start = 1'b1;
    @(posedge clk); #1;
    m16.start = 1'b0;
    m16.x = '0;
    m16.y = '0;
    wait_idle(16);
    repeat (4) @(negedge clk);
    check("ignore_start", 64'(m16.product), 64'h00061D78);
    check("one_done", 64'(dn16 - d0), 64'd1);

    d0 = dn16;
    @(posedge clk); #1;
    m16.x = 16'h00FF;
    m16.y = 16'h0101;
    m16.is_signed = 1'b0;
    m16.start = 1'b1;
    @(posedge clk); #1;
    m16.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 64'(m16.ready), 64'd1);
    check("mid_rst_done", 64'(m16.done), 64'd0);
    check("mid_rst_prod", 64'(m16.product), 64'd0);
    repeat (12) @(negedge clk);
    check("mid_rst_nodone", 64'(dn16 - d0), 64'd0);
    do_op16(16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, "after_rst");

    b2b = 1;
    prev16 = -1;
    tgt = push16 + 12;
    n = 0;
    m16.start = 1'b1;
    while (push16 < tgt && n < 1000) begin
      @(posedge clk); #1;
      m16.x = 16'($urandom);
      m16.y = 16'($urandom);
      m16.is_signed = 1'($urandom_range(0, 1));
      n++;
    end
    m16.start = 1'b0;
    if (push16 < tgt) check("rand16_stall", 64'd1, 64'd0);
    wait_idle(16);

    prev8 = -1;
    tgt = push8 + 16;
    n = 0;
    m8.start = 1'b1;
    while (push8 < tgt && n < 1000) begin
      @(posedge clk); #1;
      m8.x = 8'($urandom);
      m8.y = 8'($urandom);
      m8.is_signed = 1'($urandom_range(0, 1));
      n++;
    end
    m8.start = 1'b0;
    if (push8 < tgt) check("rand8_stall", 64'd1, 64'd0);
    wait_idle(8);
    b2b = 0;
    check("cnt8", 64'(dn8), 64'(push8));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
